// File: rtl/wb_pkg.sv
// Shared constants for the writeback arbiter: datapath width, requester count/indices,
// and register-index geometry.
// No logic; imported by wb_arbiter and its testbench.
package wb_pkg;
    localparam int XLEN    = 32;   // register-file write data width
    localparam int NREQ    = 3;    // number of writeback requesters
    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;
    localparam int RIDX_W  = 5;    // register index width
    localparam int NREG    = 32;   // architectural registers tracked by the scoreboard
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant: search starts at ptr_i, ascends with wrap, first valid wins.
// Latency: purely combinational, zero cycles.
// Backpressure: none; grant is all-zero when no input is valid.
// Ports: valid_i (request vector), ptr_i (search start index), grant_o (one-hot grant).
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && valid_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin selects one requester per cycle, registers the write to
// the register file, and keeps a busy scoreboard of registers awaiting writeback.
// Latency: transfer in cycle T appears on rf_a3/rf_wd in T+1; busy clears at the end of T+1.
// Backpressure: one transfer accepted every cycle; losers wait with req_ready low.
// Ports: clk/res_n; req_valid/req_rd/req_data/req_ready (per-requester handshake);
//        iss_valid/iss_rd (mark busy); busy (scoreboard); rf_a3/rf_wd (registered RF write).
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN = wb_pkg::XLEN,
    parameter int NREQ = wb_pkg::NREQ
) (
    input  logic                   clk,
    input  logic                   res_n,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [RIDX_W*NREQ-1:0] req_rd,
    input  logic [XLEN*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]        req_ready,
    input  logic                   iss_valid,
    input  logic [RIDX_W-1:0]      iss_rd,
    output logic [NREG-1:0]        busy,
    output logic [RIDX_W-1:0]      rf_a3,
    output logic [XLEN-1:0]        rf_wd
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]   grant;
    logic              xfer;
    logic [PW-1:0]     sel_idx;
    logic [RIDX_W-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    logic              wr_vld_q, wr_vld_d;
    logic [RIDX_W-1:0] rf_a3_q, rf_a3_d;
    logic [XLEN-1:0]   rf_wd_q, rf_wd_d;
    logic [NREG-1:0]   busy_q, busy_d;

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .valid_i (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Grant is masked during reset so no requester sees a handshake it could retire on.
    assign req_ready = res_n ? grant : '0;
    // Registers are held in reset, so the unmasked grant is sufficient for state updates.
    assign xfer      = |grant;

    always_comb begin
        sel_idx  = '0;
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_idx  = PW'(i);
                sel_rd   = req_rd[RIDX_W*i +: RIDX_W];
                sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (sel_idx == PW'(NREQ - 1)) ? '0 : PW'(sel_idx + PW'(1));
        end
    end

    // The register file has no write enable, so idle cycles and x0 writes both drive
    // address 0 with zero data; only real writes set the pending-valid flag.
    always_comb begin
        wr_vld_d = xfer && (sel_rd != '0);
        rf_a3_d  = wr_vld_d ? sel_rd   : '0;
        rf_wd_d  = wr_vld_d ? sel_data : '0;
    end

    // Clear applies first so a same-edge set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_vld_q) begin
            busy_d[rf_a3_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ptr_q    <= '0;
            wr_vld_q <= 1'b0;
            rf_a3_q  <= '0;
            rf_wd_q  <= '0;
            busy_q   <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_vld_q <= wr_vld_d;
            rf_a3_q  <= rf_a3_d;
            rf_wd_q  <= rf_wd_d;
            busy_q   <= busy_d;
        end
    end

    assign rf_a3 = rf_a3_q;
    assign rf_wd = rf_wd_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed table-driven bench for wb_arbiter plus a hand-written mid-operation reset sequence.
module tb_wb_arbiter;

    logic        clk;
    logic        res_n;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [31:0] busy;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  v;
        logic [14:0] rd;
        logic [95:0] dat;
        logic        iv;
        logic [4:0]  ir;
        logic [2:0]  er;
        logic [4:0]  ea3;
        logic [31:0] ewd;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vecs[$];

    wb_arbiter #(
        .XLEN (32),
        .NREQ (3)
    ) dut (
        .clk       (clk),
        .res_n     (res_n),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .rf_a3     (rf_a3),
        .rf_wd     (rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [2:0] v,
                       input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic iv, input logic [4:0] ir,
                       input logic [2:0] er, input logic [4:0] ea3,
                       input logic [31:0] ewd, input logic [31:0] ebusy);
        vec_t t;
        t.v = v; t.rd = {r2, r1, r0}; t.dat = {d2, d1, d0};
        t.iv = iv; t.ir = ir; t.er = er; t.ea3 = ea3; t.ewd = ewd; t.ebusy = ebusy;
        vecs.push_back(t);
    endtask

    task automatic idle_in();
        req_valid = '0; req_rd = '0; req_data = '0; iss_valid = 1'b0; iss_rd = '0;
    endtask

    initial begin
        idle_in();
        res_n = 1'b0;

        // Reset state; grant must stay masked even with every requester valid.
        req_valid = 3'b111;
        #12;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_a3",    32'(rf_a3),     32'h0);
        chk("rst_wd",    rf_wd,          32'h0);
        chk("rst_busy",  busy,           32'h0);
        idle_in();
        @(negedge clk);
        res_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle after reset.
        for (int i = 0; i < 5; i++)
            add(3'b000, 0,0,0, 0,0,0, 0,0, 3'b000, 0, 0, 0);
        // Round robin with all valid, then partial-valid patterns and wrap from index 2.
        add(3'b111, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b001, 5, 32'hA, 0);
        add(3'b111, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b010, 6, 32'hB, 0);
        add(3'b111, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b100, 7, 32'hC, 0);
        add(3'b111, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b001, 5, 32'hA, 0);
        add(3'b101, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b100, 7, 32'hC, 0);
        add(3'b010, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b010, 6, 32'hB, 0);
        add(3'b001, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b001, 5, 32'hA, 0);
        add(3'b000, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b000, 0, 0,     0);
        add(3'b101, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b100, 7, 32'hC, 0);
        add(3'b110, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b010, 6, 32'hB, 0);
        add(3'b011, 5,6,7, 32'hA,32'hB,32'hC, 0,0, 3'b001, 5, 32'hA, 0);
        // Scoreboard: mark x9 busy, LSU writes it two cycles later.
        add(3'b000, 0,0,0, 0,0,0, 1,9, 3'b000, 0, 0, 32'h200);
        add(3'b000, 0,0,0, 0,0,0, 0,0, 3'b000, 0, 0, 32'h200);
        add(3'b010, 0,9,0, 0,32'h1234,0, 0,0, 3'b010, 9, 32'h1234, 32'h200);
        add(3'b000, 0,0,0, 0,0,0, 0,0, 3'b000, 0, 0, 32'h0);
        // Same-register set and clear on one edge: set wins.
        add(3'b001, 3,0,0, 32'h33,0,0, 1,3, 3'b001, 3, 32'h33, 32'h8);
        add(3'b000, 0,0,0, 0,0,0, 1,3, 3'b000, 0, 0, 32'h8);
        // Different registers on one edge: both take effect.
        add(3'b001, 3,0,0, 32'h44,0,0, 1,10, 3'b001, 3, 32'h44, 32'h408);
        add(3'b000, 0,0,0, 0,0,0, 0,0, 3'b000, 0, 0, 32'h400);
        add(3'b001, 10,0,0, 32'h1,0,0, 0,0, 3'b001, 10, 32'h1, 32'h400);
        add(3'b000, 0,0,0, 0,0,0, 1,11, 3'b000, 0, 0, 32'h800);
        add(3'b010, 0,11,0, 0,32'h55,0, 0,0, 3'b010, 11, 32'h55, 32'h800);
        add(3'b000, 0,0,0, 0,0,0, 0,0, 3'b000, 0, 0, 32'h0);
        // Clear of a register that is not busy.
        add(3'b100, 0,0,20, 0,0,32'h66, 0,0, 3'b100, 20, 32'h66, 32'h0);
        add(3'b000, 0,0,0, 0,0,0, 1,17, 3'b000, 0, 0, 32'h20000);
        // Write to x0 is discarded; iss_rd=0 never marks busy.
        add(3'b001, 0,0,0, 32'hFFFFFFFF,0,0, 1,0, 3'b001, 0, 0, 32'h20000);
        add(3'b000, 0,0,0, 0,0,0, 0,0, 3'b000, 0, 0, 32'h20000);

        foreach (vecs[i]) begin
            req_valid = vecs[i].v;
            req_rd    = vecs[i].rd;
            req_data  = vecs[i].dat;
            iss_valid = vecs[i].iv;
            iss_rd    = vecs[i].ir;
            #3;
            chk($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].er));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_a3", i),   32'(rf_a3), 32'(vecs[i].ea3));
            chk($sformatf("v%0d_wd", i),   rf_wd,      vecs[i].ewd);
            chk($sformatf("v%0d_busy", i), busy,       vecs[i].ebusy);
        end

        // Mid-operation reset: pending write of x12 must be dropped.
        req_valid = 3'b001; req_rd = {5'd0, 5'd0, 5'd12}; req_data = {64'h0, 32'hC0DE};
        iss_valid = 1'b1; iss_rd = 5'd12;
        #3;
        chk("mr_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("mr_a3",   32'(rf_a3), 32'd12);
        chk("mr_busy", busy,       32'h21000);
        idle_in();
        req_valid = 3'b111; req_rd = {5'd7, 5'd6, 5'd5}; req_data = {32'hC, 32'hB, 32'hA};
        #1;
        res_n = 1'b0;
        #1;
        chk("mr_rst_a3",    32'(rf_a3),     32'h0);
        chk("mr_rst_wd",    rf_wd,          32'h0);
        chk("mr_rst_busy",  busy,           32'h0);
        chk("mr_rst_ready", 32'(req_ready), 32'h0);
        @(negedge clk);
        res_n = 1'b1;
        req_valid = 3'b000;
        @(posedge clk);
        #1;
        chk("mr_post_a3",   32'(rf_a3), 32'h0);
        chk("mr_post_wd",   rf_wd,      32'h0);
        chk("mr_post_busy", busy,       32'h0);
        // Pointer was 1 before reset; after reset search restarts at requester 0.
        req_valid = 3'b111;
        #3;
        chk("mr_ptr_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("mr_ptr_a3", 32'(rf_a3), 32'd5);
        chk("mr_ptr_wd", rf_wd,      32'hA);
        idle_in();
        @(posedge clk);
        #1;
        chk("end_a3", 32'(rf_a3), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
